// File: rtl/karatsuba_mul64_ctrl.sv
// Sequencer that builds an RV64M 64x64 multiply from three passes through a shared
// 34-bit Karatsuba multiplier (LL, HH, MM), then combines and applies the sign.
module karatsuba_mul64_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        mul_start,
  output logic [33:0] mul_a,
  output logic [33:0] mul_b,
  input  logic [67:0] mul_s,
  input  logic        mul_done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LO, WAIT_HI, COMBINE, FIX, OUT
  } state_t;

  state_t       r_state, w_next;
  logic [1:0]   r_step;
  logic [1:0]   r_op;
  logic         r_sa, r_sb;
  logic [63:0]  r_a, r_b;
  logic [63:0]  r_ll, r_hh;
  logic [67:0]  r_mm;
  logic [127:0] r_p;

  logic         w_sa, w_sb;
  logic [63:0]  w_absA, w_absB;
  logic [32:0]  w_sumA, w_sumB;
  logic [67:0]  w_mid;
  logic [127:0] w_comb;

  assign w_sa   = ((in_op == 2'b01) || (in_op == 2'b10)) && in_a[63];
  assign w_sb   = (in_op == 2'b01) && in_b[63];
  assign w_absA = w_sa ? (~in_a + 64'd1) : in_a;
  assign w_absB = w_sb ? (~in_b + 64'd1) : in_b;

  assign w_sumA = {1'b0, r_a[31:0]} + {1'b0, r_a[63:32]};
  assign w_sumB = {1'b0, r_b[31:0]} + {1'b0, r_b[63:32]};

  // The Karatsuba middle term MM-HH-LL is nonnegative, so plain unsigned math suffices.
  assign w_mid  = r_mm - {4'b0, r_hh} - {4'b0, r_ll};
  assign w_comb = {r_hh, 64'b0} + ({60'b0, w_mid} << 32) + {64'b0, r_ll};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT_LO;
      WAIT_LO: if (!mul_done) w_next = WAIT_HI;
      WAIT_HI: if (mul_done) w_next = (r_step == 2'd2) ? COMBINE : ISSUE;
      COMBINE: w_next = FIX;
      FIX:     w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= 2'd0;
      r_op   <= 2'd0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_ll   <= '0;
      r_hh   <= '0;
      r_mm   <= '0;
      r_p    <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_op   <= in_op;
          r_sa   <= w_sa;
          r_sb   <= w_sb;
          r_a    <= w_absA;
          r_b    <= w_absB;
          r_step <= 2'd0;
        end
        WAIT_HI: if (mul_done) begin
          case (r_step)
            2'd0:    r_ll <= mul_s[63:0];
            2'd1:    r_hh <= mul_s[63:0];
            default: r_mm <= mul_s;
          endcase
          if (r_step != 2'd2) r_step <= r_step + 2'd1;
        end
        COMBINE: r_p <= w_comb;
        FIX:     if (r_sa ^ r_sb) r_p <= ~r_p + 128'd1;
        default: ;
      endcase
    end
  end

  // Operands depend only on step and latched magnitudes, so they hold through the wait states.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (r_step)
      2'd0: begin
        mul_a = {2'b0, r_a[31:0]};
        mul_b = {2'b0, r_b[31:0]};
      end
      2'd1: begin
        mul_a = {2'b0, r_a[63:32]};
        mul_b = {2'b0, r_b[63:32]};
      end
      default: begin
        mul_a = {1'b0, w_sumA};
        mul_b = {1'b0, w_sumB};
      end
    endcase
  end

  assign in_ready   = (r_state == IDLE);
  assign mul_start  = (r_state == ISSUE);
  assign out_valid  = (r_state == OUT);
  assign out_result = (r_op == 2'b00) ? r_p[63:0] : r_p[127:64];

endmodule

// File: tb/tb_karatsuba_mul64_ctrl.sv
// Bench for karatsuba_mul64_ctrl: behavioural multiplier with random latency, directed
// corners, backpressure, mid-op reset and random requests against a 128-bit model.
module tb_karatsuba_mul64_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        mul_start;
  logic [33:0] mul_a, mul_b;
  logic [67:0] mul_s = '0;
  logic        mul_done = 1'b0;

  int errors = 0;
  int checks = 0;

  karatsuba_mul64_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // Stand-in for karatsuba_34b: done drops on start and rises 1..4 cycles later, then stays high.
  logic [67:0] mulProd = '0;
  int          mulCnt = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      mul_done <= 1'b0;
      mulCnt   <= int'($urandom_range(1, 4));
      mulProd  <= {34'b0, mul_a} * {34'b0, mul_b};
    end else if (mulCnt > 0) begin
      mulCnt <= mulCnt - 1;
      if (mulCnt == 1) begin
        mul_done <= 1'b1;
        mul_s    <= mulProd;
      end
    end
  end

  // Start-pulse and operand-stability monitor; the main sequence looks at count deltas.
  int          startCnt = 0;
  int          wideCnt = 0;
  int          stabViol = 0;
  bit          trk = 1'b0;
  bit          prevStart = 1'b0;
  logic [33:0] capA = '0, capB = '0;
  always @(negedge clk) begin
    if (mul_start) begin
      startCnt++;
      if (prevStart) wideCnt++;
      trk  = 1'b1;
      capA = mul_a;
      capB = mul_b;
    end else if (trk) begin
      if (mul_a !== capA || mul_b !== capB) stabViol++;
      if (mul_done) trk = 1'b0;
    end
    prevStart = mul_start;
  end

  function automatic logic [63:0] refMul(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic issueReq(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bit ready;
    ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("in_ready_wait", {63'b0, ready}, 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                               input int duty, output logic [63:0] res);
    bit got;
    got = 1'b0;
    res = '0;
    issueReq(op, a, b);
    for (int i = 0; i < 1000; i++) begin
      out_ready = ($urandom_range(0, 99) < duty);
      if (out_valid && out_ready) begin
        res = out_result;
        got = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checkOutput("out_valid_wait", {63'b0, got}, 64'd1);
  endtask

  initial begin
    logic [63:0] res, r0, ra, rb;
    logic [1:0]  rop;
    int          s0, w0, v0, seen;
    bit          bad, got;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready",   {63'b0, in_ready},  64'd1);
    checkOutput("rst_out_valid",  {63'b0, out_valid}, 64'd0);
    checkOutput("rst_out_result", out_result,         64'd0);
    checkOutput("rst_mul_start",  {63'b0, mul_start}, 64'd0);
    checkOutput("rst_mul_a",      {30'b0, mul_a},     64'd0);
    checkOutput("rst_mul_b",      {30'b0, mul_b},     64'd0);
    rst_n = 1'b1;

    // Directed corners, with start-pulse bookkeeping around the first one
    s0 = startCnt; w0 = wideCnt; v0 = stabViol;
    applyStimulus(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 100, res);
    checkOutput("mulhu_ones", res, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("start_count", 64'(startCnt - s0), 64'd3);
    checkOutput("start_wide",  64'(wideCnt - w0),  64'd0);
    checkOutput("operand_stab", 64'(stabViol - v0), 64'd0);
    applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 100, res);
    checkOutput("mul_ones", res, 64'h0000_0000_0000_0001);
    applyStimulus(2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 100, res);
    checkOutput("mulh_min_neg1", res, 64'h0000_0000_0000_0000);
    applyStimulus(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 100, res);
    checkOutput("mulhsu_neg1", res, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 100, res);
    checkOutput("mul_m3x7", res, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(2'b11, 64'd0, 64'hDEAD_BEEF_0000_1234, 60, res);
    checkOutput("mulhu_zero", res, 64'd0);

    // Backpressure: hold out_ready low for 10 cycles once out_valid rises
    issueReq(2'b01, 64'h9234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("bp_valid_wait", {63'b0, got}, 64'd1);
    r0  = out_result;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_result !== r0 || in_ready !== 1'b0 || mul_start !== 1'b0 || out_valid !== 1'b1)
        bad = 1'b1;
    end
    checkOutput("bp_hold", {63'b0, bad}, 64'd0);
    checkOutput("bp_result", r0, refMul(2'b01, 64'h9234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("bp_release_idle",  {63'b0, in_ready},  64'd1);

    // Reset during WAIT_HI of the HH pass
    issueReq(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444);
    seen = 1;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(posedge clk);
      #1;
      if (mul_start) seen++;
    end
    checkOutput("mid_second_start", 64'(seen), 64'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready",   {63'b0, in_ready},  64'd1);
    checkOutput("mid_rst_out_valid",  {63'b0, out_valid}, 64'd0);
    checkOutput("mid_rst_out_result", out_result,         64'd0);
    checkOutput("mid_rst_mul_start",  {63'b0, mul_start}, 64'd0);
    checkOutput("mid_rst_mul_ab",     {mul_a[31:0], mul_b[31:0]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, 64'd5, 64'd6, 100, res);
    checkOutput("post_rst_5x6", res, 64'd30);

    // Random requests against the 128-bit model
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'h8000_0000_0000_0000;
        1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        2: ra = {32'b0, ra[31:0]};
        default: ;
      endcase
      applyStimulus(rop, ra, rb, int'($urandom_range(30, 100)), res);
      checkOutput($sformatf("rand%0d_op%0d", n, rop), res, refMul(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/karatsuba_mul64_ctrl.md
# karatsuba_mul64_ctrl

Sequencing controller that builds an RV64M 64×64 multiply out of three passes through one shared `karatsuba_34b` instance, using one level of Karatsuba: LL = aL·bL, HH = aH·bH, MM = (aL+aH)·(bL+bH). The 33-bit half-sums fit the multiplier's 34-bit operands. The block sits between the integer execute stage and the multiplier. It owns the multiplier's start/done handshake, handles signedness for MUL/MULH/MULHSU/MULHU, and returns the selected 64-bit result over a valid/ready interface.

## Interface
- No parameters. Widths are fixed by `karatsuba_34b` (34b operands, 68b product).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: controller idle; request accepted when `in_valid && in_ready`.
- `in_op` in 2: 00 MUL (low 64), 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u).
- `in_a`, `in_b` in 64 each: operands (rs1, rs2).
- `out_valid` out 1: result valid; held until accepted.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_result` out 64: selected half of the 128-bit product.
- `mul_start` out 1: to `karatsuba_34b.start`.
- `mul_a`, `mul_b` out 34 each: to `karatsuba_34b.a` / `.b`.
- `mul_s` in 68: from `karatsuba_34b.s`.
- `mul_done` in 1: from `karatsuba_34b.done`.

## Operation
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, COMBINE, FIX, OUT. A 2-bit `step` register (0=LL, 1=HH, 2=MM) selects the product in flight.
- **IDLE:** `in_ready`=1. On accept:
  - Latch op and sign flags. sa = a[63] for MULH and MULHSU; sb = b[63] for MULH only; MUL forces both to 0.
  - Latch magnitudes |a| and |b| as 64-bit unsigned. -2^63 maps to 2^63.
  - Set step=0 and go to ISSUE.
- **ISSUE:** `mul_start`=1 for exactly one cycle, then go to WAIT_LO.
- **Operands by step:**
  - step 0: {2'b0, aL} × {2'b0, bL}.
  - step 1: {2'b0, aH} × {2'b0, bH}.
  - step 2: {1'b0, aL+aH} × {1'b0, bL+bH}.
  - `mul_a`/`mul_b` stay stable from ISSUE through WAIT_HI.
- **WAIT_LO:** wait until `mul_done`=0. This guards against a stale `done` left over from the previous product.
- **WAIT_HI:** wait until `mul_done`=1.
  - Capture `mul_s`: LL (64b) at step 0, HH (64b) at step 1, MM (66b) at step 2.
  - If step<2: increment step and go to ISSUE. Otherwise go to COMBINE.
- **COMBINE:** P = (HH<<64) + ((MM − HH − LL)<<32) + LL.
  - The middle term is nonnegative and at most 65 bits.
  - Use a 128-bit unsigned accumulator. Overflow beyond 128 bits cannot occur.
- **FIX:** if sa XOR sb, set P = −P (128-bit two's complement). Otherwise P is unchanged.
- **OUT:** `out_valid`=1. `out_result` = P[63:0] for MUL, P[127:64] otherwise. On `out_ready`, go to IDLE.
  - `in_ready` stays 0 until IDLE. There is no same-cycle back-to-back accept.
- **Zero operands:** no shortcut; all three passes always run.
- **Reset** (asynchronous, any state, including mid-product):
  - State goes to IDLE and step to 0.
  - `out_valid`=0, `out_result`=0, `mul_start`=0, `mul_a`=`mul_b`=0, all product registers 0; `in_ready`=1 once state is IDLE.
  - The multiplier's in-flight result is discarded. The first ISSUE after reset waits in WAIT_LO for `mul_done` low as normal.
- **Undefined input:** `mul_done` rising outside WAIT_HI is ignored.

## Timing
- Let D = cycles from `mul_start` high until `mul_done` is observed high, including the WAIT_LO cycle(s).
- Latency from the accept edge to `out_valid` high = 3·(1 + D) + 2 cycles (ISSUE plus waits per pass, then COMBINE and FIX).
- `out_valid`, `out_result`, `in_ready` and `mul_*` are registered or decoded from state only; no combinational path from inputs.
- While `out_valid`=1 and `out_ready`=0, `out_result` is held constant.
- Throughput: one request per (latency + 1) cycles at best.

## Test plan
- **MULHU all-ones:** a = b = 0xFFFF_FFFF_FFFF_FFFF → `out_result` = 0xFFFF_FFFF_FFFF_FFFE. MUL on the same operands → 0x0000_0000_0000_0001.
- **Signed corners:**
  - MULH, a = 0x8000_0000_0000_0000, b = −1 → 0x0000_0000_0000_0000.
  - MULHSU, a = −1, b = 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF.
  - MUL, a = −3, b = 7 → 0xFFFF_FFFF_FFFF_FFEB.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` rises. Check `out_result` stable, `in_ready`=0, `mul_start`=0 throughout. Release and check a single handshake and return to IDLE.
- **Handshake:** count `mul_start` pulses per request; expect exactly 3, each 1 cycle wide. Check `mul_a`/`mul_b` stable from ISSUE until `mul_done` is high.
- **Reset mid-op:** assert `rst_n`=0 during WAIT_HI of step 1. Outputs must reach reset values asynchronously. The next request a=5, b=6 under MUL returns 30.
- **Random:** 200 random requests across all `in_op` values with a random `out_ready` duty cycle, checked against a 128-bit reference model.
